// File: rtl/dmem_responder.sv
// dmem_responder: memory end of the core dmem port, word RAM with load latency
// and SB/SH lane steering. `DMEM_RSP_JITTER_EN adds LFSR-driven load wait states.
module dmem_responder #(
  parameter int    ADDR_W    = 14,
  parameter int    READ_LAT  = 1,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic        mem_oe,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_we,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        misalign_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int DEPTH = 1 << ADDR_W;

  state_t            state;
  logic [4:0]        cnt;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ram [DEPTH];

  logic [ADDR_W-1:0] word;
  logic [1:0]        s;
  logic [7:0]        be_wide;
  logic [3:0]        be;
  logic [31:0]       wd;
  logic              accept;
  logic              ld_acc;
  logic              st_acc;
  logic              st_ovf;
  logic              st_wr;
  logic [4:0]        extra;
  logic [4:0]        lat;
  logic              unused;

  assign word    = mem_addr[ADDR_W+1:2];
  assign s       = mem_addr[1:0];
  assign be_wide = {4'b0000, mem_we} << s;
  assign be      = be_wide[3:0];
  assign wd      = mem_wdata << {s, 3'b000};
  assign st_ovf  = |be_wide[7:4];
  assign accept  = mem_oe && (state != WAIT);
  assign ld_acc  = accept && (mem_we == 4'b0000);
  assign st_acc  = accept && (mem_we != 4'b0000);
  assign st_wr   = st_acc && !st_ovf && rst_n;
  assign lat     = 5'(READ_LAT - 1) + extra;
  assign unused  = ^{mem_addr[31:ADDR_W+2]};

`ifdef DMEM_RSP_JITTER_EN
  logic [7:0] lfsr;

  // x^8+x^6+x^5+x^4+1, advanced once per accepted load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 8'hA5;
    end else if (ld_acc) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign extra = {3'b000, lfsr[1:0]};
`else
  assign extra = 5'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mem_ready    <= 1'b1;
      mem_rdata    <= '0;
      misalign_err <= 1'b0;
      cnt          <= '0;
      ld_addr      <= '0;
    end else begin
      if (st_acc && st_ovf) begin
        misalign_err <= 1'b1;
      end
      unique case (state)
        WAIT: begin
          if (cnt == 5'd1) begin
            state     <= RESP;
            mem_ready <= 1'b1;
            mem_rdata <= ram[ld_addr];
            cnt       <= '0;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: begin
          if (ld_acc) begin
            ld_addr <= word;
            if (lat == 5'd0) begin
              state     <= RESP;
              mem_ready <= 1'b1;
              mem_rdata <= ram[word];
              cnt       <= '0;
            end else begin
              state     <= WAIT;
              mem_ready <= 1'b0;
              cnt       <= lat;
            end
          end else begin
            state     <= IDLE;
            mem_ready <= 1'b1;
          end
        end
      endcase
    end
  end

  // RAM has no reset: contents survive rst_n
  always_ff @(posedge clk) begin
    if (st_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          ram[word][8*i +: 8] <= wd[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: three responders (READ_LAT 1,2,3) against a byte-level
// memory model; directed scenarios plus randomized load/store traffic.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn  [3];
  logic [31:0] addr  [3];
  logic        oe    [3];
  logic [31:0] wdata [3];
  logic [3:0]  we    [3];
  logic [31:0] rdata [3];
  logic        ready [3];
  logic        merr  [3];

  dmem_responder #(.READ_LAT(1)) u0 (
    .clk(clk), .rst_n(rstn[0]), .mem_addr(addr[0]), .mem_oe(oe[0]),
    .mem_wdata(wdata[0]), .mem_we(we[0]), .mem_rdata(rdata[0]),
    .mem_ready(ready[0]), .misalign_err(merr[0]));

  dmem_responder #(.READ_LAT(2)) u1 (
    .clk(clk), .rst_n(rstn[1]), .mem_addr(addr[1]), .mem_oe(oe[1]),
    .mem_wdata(wdata[1]), .mem_we(we[1]), .mem_rdata(rdata[1]),
    .mem_ready(ready[1]), .misalign_err(merr[1]));

  dmem_responder #(.READ_LAT(3)) u2 (
    .clk(clk), .rst_n(rstn[2]), .mem_addr(addr[2]), .mem_oe(oe[2]),
    .mem_wdata(wdata[2]), .mem_we(we[2]), .mem_rdata(rdata[2]),
    .mem_ready(ready[2]), .misalign_err(merr[2]));

`ifdef DMEM_RSP_JITTER_EN
  localparam int EXTRA = 3;
`else
  localparam int EXTRA = 0;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] rmem [3][64];
  bit          merr_m [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_store(input int k, input logic [31:0] a,
                             input logic [3:0] w, input logic [31:0] d);
    int s;
    bit ovf;
    s = int'(a[1:0]);
    ovf = 0;
    for (int j = 0; j < 4; j++) if (w[j] && s + j > 3) ovf = 1;
    if (ovf) merr_m[k] = 1;
    else
      for (int j = 0; j < 4; j++)
        if (w[j]) rmem[k][a[7:2]][8*(s+j) +: 8] = d[8*j +: 8];
  endtask

  task automatic do_store(input int k, input logic [31:0] a,
                          input logic [3:0] w, input logic [31:0] d);
    addr[k] = a; we[k] = w; wdata[k] = d; oe[k] = 1'b1;
    tick();
    oe[k] = 1'b0; we[k] = 4'h0;
    model_store(k, a, w, d);
  endtask

  task automatic do_load(input int k, input logic [31:0] a,
                         output logic [31:0] d, output int n);
    addr[k] = a; we[k] = 4'h0; oe[k] = 1'b1;
    tick();
    oe[k] = 1'b0;
    n = 1;
    while (!ready[k] && n < 40) begin
      tick();
      n++;
    end
    d = rdata[k];
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      rstn[k] = 1'b0; oe[k] = 1'b0; we[k] = 4'h0;
      addr[k] = '0; wdata[k] = '0; merr_m[k] = 0;
    end
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (ready[k] !== 1'b1) begin
        n_bad++; $display("FAIL reset_ready k=%0d got=%b exp=1", k, ready[k]);
      end
      n_cmp++;
      if (rdata[k] !== 32'h0) begin
        n_bad++; $display("FAIL reset_rdata k=%0d got=%h exp=0", k, rdata[k]);
      end
      n_cmp++;
      if (merr[k] !== 1'b0) begin
        n_bad++; $display("FAIL reset_merr k=%0d got=%b exp=0", k, merr[k]);
      end
    end
    for (int k = 0; k < 3; k++) rstn[k] = 1'b1;
    tick();
  endtask

  task automatic fill_all();
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 64; w++)
        do_store(k, 32'(w) << 2, 4'hF, $urandom);
  endtask

  task automatic test_store_load();
    logic [31:0] d;
    int n;
    do_store(0, 32'h10, 4'hF, 32'hDEADBEEF);
    n_cmp++;
    if (ready[0] !== 1'b1) begin
      n_bad++; $display("FAIL sw_ready got=%b exp=1", ready[0]);
    end
    do_load(0, 32'h10, d, n);
    n_cmp++;
    if (d !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL sw_lw_data got=%h exp=deadbeef", d);
    end
    n_cmp++;
    if (n < 1 || n > 1 + EXTRA) begin
      n_bad++; $display("FAIL sw_lw_lat got=%0d exp=1..%0d", n, 1 + EXTRA);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d;
    int n;
    do_store(0, 32'h10, 4'hF, 32'h11223344);
    do_store(0, 32'h13, 4'h1, 32'h000000AB);
    do_load(0, 32'h10, d, n);
    n_cmp++;
    if (d !== 32'hAB223344) begin
      n_bad++; $display("FAIL sb_lane got=%h exp=ab223344", d);
    end
    do_store(0, 32'h12, 4'h3, 32'h00005566);
    do_load(0, 32'h10, d, n);
    n_cmp++;
    if (d !== 32'h55663344) begin
      n_bad++; $display("FAIL sh_lane got=%h exp=55663344", d);
    end
  endtask

  task automatic test_wait_ignore();
    logic [31:0] d;
    logic [31:0] exp_ld;
    int n;
    exp_ld = rmem[2][12];
    addr[2] = 32'h30; we[2] = 4'h0; oe[2] = 1'b1;
    tick();
    n = 1;
    n_cmp++;
    if (ready[2] !== 1'b0) begin
      n_bad++; $display("FAIL wait_ready_t1 got=%b exp=0", ready[2]);
    end
    addr[2] = 32'h24; we[2] = 4'hF; wdata[2] = 32'hBAD00001;
    tick();
    n++;
    n_cmp++;
    if (ready[2] !== 1'b0) begin
      n_bad++; $display("FAIL wait_ready_t2 got=%b exp=0", ready[2]);
    end
    while (!ready[2] && n < 40) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n < 3 || n > 3 + EXTRA) begin
      n_bad++; $display("FAIL wait_lat got=%0d exp=3..%0d", n, 3 + EXTRA);
    end
    n_cmp++;
    if (rdata[2] !== exp_ld) begin
      n_bad++; $display("FAIL wait_data got=%h exp=%h", rdata[2], exp_ld);
    end
    addr[2] = 32'h20; wdata[2] = 32'h600DF00D;
    tick();
    oe[2] = 1'b0; we[2] = 4'h0;
    model_store(2, 32'h20, 4'hF, 32'h600DF00D);
    do_load(2, 32'h24, d, n);
    n_cmp++;
    if (d !== rmem[2][9]) begin
      n_bad++; $display("FAIL wait_store_ignored got=%h exp=%h", d, rmem[2][9]);
    end
    do_load(2, 32'h20, d, n);
    n_cmp++;
    if (d !== 32'h600DF00D) begin
      n_bad++; $display("FAIL resp_store_taken got=%h exp=600df00d", d);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int m;
    addr[1] = 32'h0; we[1] = 4'h0; oe[1] = 1'b1;
    tick();
    oe[1] = 1'b0;
    n = 1;
    while (!ready[1] && n < 40) begin
      tick();
      n++;
    end
    n_cmp++;
    if (rdata[1] !== rmem[1][0]) begin
      n_bad++; $display("FAIL b2b_first got=%h exp=%h", rdata[1], rmem[1][0]);
    end
    addr[1] = 32'h4; oe[1] = 1'b1;
    tick();
    oe[1] = 1'b0;
    m = 1;
    while (!ready[1] && m < 40) begin
      tick();
      m++;
    end
    n_cmp++;
    if (rdata[1] !== rmem[1][1]) begin
      n_bad++; $display("FAIL b2b_second got=%h exp=%h", rdata[1], rmem[1][1]);
    end
    n_cmp++;
    if (n < 2 || n > 2 + EXTRA || m < 2 || m > 2 + EXTRA) begin
      n_bad++; $display("FAIL b2b_spacing got=%0d,%0d exp=2..%0d", n, m, 2 + EXTRA);
    end
  endtask

  task automatic test_store_in_resp();
    logic [31:0] d;
    logic [31:0] old;
    int n;
    old = rmem[1][16];
    addr[1] = 32'h40; we[1] = 4'h0; oe[1] = 1'b1;
    tick();
    oe[1] = 1'b0;
    n = 1;
    while (!ready[1] && n < 40) begin
      tick();
      n++;
    end
    n_cmp++;
    if (rdata[1] !== old) begin
      n_bad++; $display("FAIL resp_load got=%h exp=%h", rdata[1], old);
    end
    we[1] = 4'hF; wdata[1] = ~old; oe[1] = 1'b1;
    tick();
    oe[1] = 1'b0; we[1] = 4'h0;
    model_store(1, 32'h40, 4'hF, ~old);
    n_cmp++;
    if (rdata[1] !== old) begin
      n_bad++; $display("FAIL resp_hold got=%h exp=%h", rdata[1], old);
    end
    do_load(1, 32'h40, d, n);
    n_cmp++;
    if (d !== ~old) begin
      n_bad++; $display("FAIL resp_after got=%h exp=%h", d, ~old);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] d;
    int n;
    n_cmp++;
    if (merr[0] !== 1'b0) begin
      n_bad++; $display("FAIL mis_pre got=%b exp=0", merr[0]);
    end
    do_store(0, 32'h2, 4'hF, 32'h12345678);
    n_cmp++;
    if (merr[0] !== 1'b1) begin
      n_bad++; $display("FAIL mis_sw got=%b exp=1", merr[0]);
    end
    do_load(0, 32'h0, d, n);
    n_cmp++;
    if (d !== rmem[0][0]) begin
      n_bad++; $display("FAIL mis_dropped got=%h exp=%h", d, rmem[0][0]);
    end
    do_store(1, 32'h7, 4'h3, 32'h0000CAFE);
    n_cmp++;
    if (merr[1] !== 1'b1) begin
      n_bad++; $display("FAIL mis_sh got=%b exp=1", merr[1]);
    end
    do_load(1, 32'h4, d, n);
    n_cmp++;
    if (d !== rmem[1][1]) begin
      n_bad++; $display("FAIL mis_sh_dropped got=%h exp=%h", d, rmem[1][1]);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    int n;
    do_store(2, 32'h3, 4'h3, 32'h00007777);
    addr[2] = 32'h30; we[2] = 4'h0; oe[2] = 1'b1;
    tick();
    oe[2] = 1'b0;
    n_cmp++;
    if (ready[2] !== 1'b0 || merr[2] !== 1'b1) begin
      n_bad++; $display("FAIL arst_pre got=%b%b exp=01", ready[2], merr[2]);
    end
    #2 rstn[2] = 1'b0;
    #1;
    n_cmp++;
    if (ready[2] !== 1'b1 || merr[2] !== 1'b0 || rdata[2] !== 32'h0) begin
      n_bad++;
      $display("FAIL arst_async got=%b%b/%h exp=10/0", ready[2], merr[2], rdata[2]);
    end
    tick();
    rstn[2] = 1'b1;
    merr_m[2] = 0;
    do_load(2, 32'h30, d, n);
    n_cmp++;
    if (d !== rmem[2][12]) begin
      n_bad++; $display("FAIL arst_ram got=%h exp=%h", d, rmem[2][12]);
    end
  endtask

`ifdef DMEM_RSP_JITTER_EN
  task automatic test_jitter();
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  seen;
    int n;
    seen = 4'h0;
    for (int i = 0; i < 256; i++) begin
      a = {24'h0, 6'($urandom), 2'b00};
      do_load(0, a, d, n);
      n_cmp++;
      if (d !== rmem[0][a[7:2]]) begin
        n_bad++; $display("FAIL jit_data i=%0d got=%h exp=%h", i, d, rmem[0][a[7:2]]);
      end
      n_cmp++;
      if (n < 1 || n > 4) begin
        n_bad++; $display("FAIL jit_lat i=%0d got=%0d exp=1..4", i, n);
      end else begin
        seen[n-1] = 1'b1;
      end
    end
    n_cmp++;
    if (seen !== 4'hF) begin
      n_bad++; $display("FAIL jit_cover got=%b exp=1111", seen);
    end
  endtask
`endif

  task automatic test_random(input int k);
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  w;
    int n;
    for (int i = 0; i < 150; i++) begin
      a = {16'($urandom), 8'h00, 6'($urandom), 2'($urandom)};
      if ($urandom_range(1, 0) == 0) begin
        do_load(k, a, d, n);
        n_cmp++;
        if (d !== rmem[k][a[7:2]]) begin
          n_bad++;
          $display("FAIL rnd_data k=%0d a=%h got=%h exp=%h", k, a, d, rmem[k][a[7:2]]);
        end
        n_cmp++;
        if (n < k + 1 || n > k + 1 + EXTRA) begin
          n_bad++; $display("FAIL rnd_lat k=%0d got=%0d exp=%0d", k, n, k + 1);
        end
      end else begin
        case ($urandom_range(3, 0))
          0:       w = 4'h1;
          1:       w = 4'h3;
          2:       w = 4'hF;
          default: w = 4'($urandom_range(15, 1));
        endcase
        do_store(k, a, w, $urandom);
        n_cmp++;
        if (merr[k] !== merr_m[k]) begin
          n_bad++; $display("FAIL rnd_merr k=%0d got=%b exp=%b", k, merr[k], merr_m[k]);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    fill_all();
    test_store_load();
    test_byte_lanes();
    test_wait_ignore();
    test_back_to_back();
    test_store_in_resp();
    test_misalign();
    test_async_reset();
`ifdef DMEM_RSP_JITTER_EN
    test_jitter();
`endif
    for (int k = 0; k < 3; k++) test_random(k);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
